moisture_sample_averager: RTL and testbench

- Measurement front-end that sits directly upstream of the pump-control FSM.
- On a measurement request: powers the soil sensor, waits a settle time, then runs 2^AVG_LOG2 ADC conversions over a start/valid handshake and averages them.
- Applies hysteresis thresholds to the average.
- Produces a single-cycle measurement_done pulse and a registered moisture_low level (1 = dry, pump needed) for the controller.

---
 rtl/soil_pkg.sv | 23 ++
 rtl/moisture_hysteresis_cmp.sv | 24 ++
 rtl/moisture_sample_averager.sv | 155 +++++++++++++++
 tb/tb_moisture_sample_averager.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soil_pkg.sv
// Shared soil-moisture definitions: averager state encoding, default ADC width
// and the moisture_low sense convention used by the averager and the pump FSM.
package soil_pkg;

  localparam int unsigned ADC_W_DEF = 12;

  // moisture_low: 1 = dry (pump needed), 0 = wet or fail-safe
  localparam logic MOISTURE_DRY = 1'b1;
  localparam logic MOISTURE_WET = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } avg_state_t;

  function automatic logic state_powers_sensor(input avg_state_t s);
    return (s == ST_SETTLE) || (s == ST_CONVERT) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/moisture_hysteresis_cmp.sv
// Hysteresis decision on a moisture average; set (dry) wins over clear when
// the thresholds are misordered.
module moisture_hysteresis_cmp
  import soil_pkg::*;
#(
  parameter int unsigned W = ADC_W_DEF
) (
  input  logic [W-1:0] avg,
  input  logic [W-1:0] thr_low,
  input  logic [W-1:0] thr_high,
  input  logic         prev_low,
  output logic         next_low
);

  always_comb begin
    next_low = prev_low;
    if (avg < thr_low) begin
      next_low = MOISTURE_DRY;
    end else if (avg > thr_high) begin
      next_low = MOISTURE_WET;
    end
  end

endmodule

// File: rtl/moisture_sample_averager.sv
// Sensor power sequencing, ADC sample averaging and hysteresis dry flag
// feeding the pump controller.
module moisture_sample_averager
  import soil_pkg::*;
#(
  parameter int unsigned ADC_W          = ADC_W_DEF,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meas_req,
  input  logic [ADC_W-1:0] thr_low,
  input  logic [ADC_W-1:0] thr_high,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             sensor_pwr_en,
  output logic             adc_start,
  output logic             busy,
  output logic             measurement_done,
  output logic             moisture_low,
  output logic [ADC_W-1:0] moisture_avg,
  output logic             timeout_err
);

  localparam int unsigned ACC_W       = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W       = AVG_LOG2 + 1;
  localparam int unsigned SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NUM_SAMPLES = 1 << AVG_LOG2;

  avg_state_t       state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] sample_cnt;

  logic [ACC_W-1:0] acc_sum;
  logic [ADC_W-1:0] avg_c;
  logic             last_sample;
  logic             tmo_expire;
  logic             next_low;

  logic pwr_nxt, start_nxt, busy_nxt, done_nxt;

  // Average including the sample arriving this cycle, ready for the DONE-entry edge
  assign acc_sum     = acc + ACC_W'(adc_data);
  assign avg_c       = ADC_W'(acc_sum >> AVG_LOG2);
  assign last_sample = (sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign tmo_expire  = (tmo_cnt == TMO_W'(1));

  moisture_hysteresis_cmp #(.W(ADC_W)) u_hyst (
    .avg      (avg_c),
    .thr_low  (thr_low),
    .thr_high (thr_high),
    .prev_low (moisture_low),
    .next_low (next_low)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (meas_req) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == '0) state_nxt = ST_CONVERT;
      ST_CONVERT: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (adc_valid) begin
          state_nxt = last_sample ? ST_DONE : ST_CONVERT;
        end else if (tmo_expire) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the next state so their registers track the state register
  always_comb begin
    pwr_nxt   = state_powers_sensor(state_nxt);
    start_nxt = (state_nxt == ST_CONVERT);
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sensor_pwr_en    <= 1'b0;
      adc_start        <= 1'b0;
      busy             <= 1'b0;
      measurement_done <= 1'b0;
    end else begin
      sensor_pwr_en    <= pwr_nxt;
      adc_start        <= start_nxt;
      busy             <= busy_nxt;
      measurement_done <= done_nxt;
    end
  end

  // Timers, accumulator and the result registers that change only on DONE entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      acc          <= '0;
      sample_cnt   <= '0;
      moisture_low <= 1'b0;
      moisture_avg <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (meas_req) begin
            settle_cnt  <= SET_W'(SETTLE_CYCLES - 1);
            acc         <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        end
        ST_CONVERT: begin
          tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end
        ST_WAIT: begin
          if (adc_valid) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (last_sample) begin
              moisture_avg <= avg_c;
              moisture_low <= next_low;
            end
          end else if (tmo_expire) begin
            timeout_err  <= 1'b1;
            moisture_low <= MOISTURE_WET;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_moisture_sample_averager.sv
// Directed bench for moisture_sample_averager: per-measurement result model,
// cycle-window expectations for control outputs, and literal spot values.
module tb_moisture_sample_averager;

  localparam int ADC_W  = 12;
  localparam int SET    = 16;
  localparam int TMO    = 1023;
  localparam int NS     = 4;
  localparam int THR_LO = 1000;
  localparam int THR_HI = 1200;

  logic             clk = 1'b0;
  logic             reset;
  logic             meas_req;
  logic [ADC_W-1:0] thr_low, thr_high, adc_data;
  logic             adc_valid;
  logic             sensor_pwr_en, adc_start, busy, measurement_done;
  logic             moisture_low, timeout_err;
  logic [ADC_W-1:0] moisture_avg;

  always #5 clk = ~clk;

  moisture_sample_averager #(
    .ADC_W(ADC_W), .AVG_LOG2(2), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .meas_req(meas_req),
    .thr_low(thr_low), .thr_high(thr_high),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .sensor_pwr_en(sensor_pwr_en), .adc_start(adc_start), .busy(busy),
    .measurement_done(measurement_done), .moisture_low(moisture_low),
    .moisture_avg(moisture_avg), .timeout_err(timeout_err)
  );

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks, n_errs;
  int req_cyc = -1000, done_cyc = -1000, last_done_cyc = -1000, done_count;
  int cur_avg, cur_low, cur_err, nxt_avg, nxt_low, nxt_err;
  bit chk_en, clear_req, late_strobe;
  int samp_q[$];
  int withhold_idx = -1;
  int conv_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the measurement-window model
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (clear_req) begin
        cur_avg = 0; cur_low = 0; cur_err = 0;
      end
      if (measurement_done) begin
        last_done_cyc = cyc;
        done_count++;
      end
      if (chk_en) begin
        if (cyc == req_cyc + 1) cur_err = 0;
        if (cyc == done_cyc) begin
          cur_avg = nxt_avg; cur_low = nxt_low; cur_err = nxt_err;
        end
        check("busy", int'(busy), int'(cyc > req_cyc && cyc <= done_cyc));
        check("sensor_pwr_en", int'(sensor_pwr_en), int'(cyc > req_cyc && cyc < done_cyc));
        check("measurement_done", int'(measurement_done), int'(cyc == done_cyc));
        if (adc_start)
          check("adc_start_window", int'(cyc > req_cyc + SET && cyc < done_cyc), 1);
        check("moisture_avg", int'(moisture_avg), cur_avg);
        check("moisture_low", int'(moisture_low), cur_low);
        check("timeout_err", int'(timeout_err), cur_err);
      end
    end
  endtask

  // ADC: answers each adc_start one cycle later, optionally withholding one conversion
  task automatic adc_model();
    bit start_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      adc_valid = 1'b0;
      if (reset) begin
        start_seen = 1'b0;
      end else begin
        if (late_strobe) begin
          adc_valid   = 1'b1;
          adc_data    = 12'(4000);
          late_strobe = 1'b0;
        end else if (start_seen) begin
          if (conv_cnt != withhold_idx && samp_q.size() > 0) begin
            adc_valid = 1'b1;
            adc_data  = 12'(samp_q.pop_front());
          end
          conv_cnt++;
        end
        start_seen = adc_start;
      end
    end
  endtask

  task automatic run_meas(input int s0, input int s1, input int s2, input int s3,
                          input int withhold, input bit extra_reqs);
    int avg;
    samp_q = {s0, s1, s2, s3};
    withhold_idx = withhold;
    conv_cnt = 0;
    if (withhold >= 0) begin
      nxt_avg = cur_avg; nxt_low = 0; nxt_err = 1;
    end else begin
      avg = (s0 + s1 + s2 + s3) / NS;
      nxt_avg = avg;
      nxt_err = 0;
      if (avg < THR_LO) nxt_low = 1;
      else if (avg > THR_HI) nxt_low = 0;
      else nxt_low = cur_low;
    end
    @(posedge clk); #1;
    meas_req = 1'b1;
    req_cyc  = cyc;
    done_cyc = cyc + ((withhold < 0) ? (1 + SET + 2 * NS) : (1 + SET + 2 * withhold + 1 + TMO));
    while (cyc < done_cyc + 2) begin
      @(posedge clk); #1;
      meas_req = extra_reqs && (cyc == req_cyc + 5 || cyc == req_cyc + 18);
    end
    meas_req = 1'b0;
    samp_q.delete();
    withhold_idx = -1;
  endtask

  task automatic check_results(input string tag, input int a, input int l, input int e);
    check({tag, "_avg"}, int'(moisture_avg), a);
    check({tag, "_low"}, int'(moisture_low), l);
    check({tag, "_err"}, int'(timeout_err), e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pwr"}, int'(sensor_pwr_en), 0);
    check({tag, "_start"}, int'(adc_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(measurement_done), 0);
    check_results(tag, 0, 0, 0);
  endtask

  initial begin
    int cnt0;
    reset = 1'b1; meas_req = 1'b0; adc_valid = 1'b0; adc_data = '0;
    thr_low = 12'(THR_LO); thr_high = 12'(THR_HI);
    fork
      monitor();
      adc_model();
    join_none
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // dry soil
    run_meas(800, 900, 1000, 1100, -1, 1'b0);
    check_results("dry", 950, 1, 0);
    check("dry_latency", last_done_cyc - req_cyc, 25);

    // hysteresis band holds, then wet clears
    run_meas(1100, 1100, 1100, 1100, -1, 1'b0);
    check_results("band", 1100, 1, 0);
    run_meas(1300, 1300, 1300, 1300, -1, 1'b0);
    check_results("wet", 1300, 0, 0);

    // truncation: 4003 >> 2 = 1000, inside band, holds 0 then holds 1
    run_meas(1001, 1001, 1001, 1000, -1, 1'b0);
    check_results("trunc0", 1000, 0, 0);
    run_meas(800, 800, 800, 800, -1, 1'b0);
    check_results("dry2", 800, 1, 0);
    run_meas(1001, 1001, 1001, 1000, -1, 1'b0);
    check_results("trunc1", 1000, 1, 0);

    // ADC timeout on the second conversion, then a late strobe in IDLE
    run_meas(700, 700, 700, 700, 1, 1'b0);
    check_results("tmo", 1000, 0, 1);
    check("tmo_latency", last_done_cyc - req_cyc, 1043);
    cnt0 = done_count;
    late_strobe = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_results("late", 1000, 0, 1);
    check("late_no_done", done_count - cnt0, 0);

    // requests during SETTLE and WAIT are ignored
    cnt0 = done_count;
    run_meas(1300, 1300, 1300, 1300, -1, 1'b1);
    check("one_done", done_count - cnt0, 1);
    check_results("ignreq", 1300, 0, 0);

    // async reset in the middle of WAIT
    samp_q = {900, 900, 900, 900};
    conv_cnt = 0;
    @(posedge clk); #1;
    meas_req = 1'b1;
    req_cyc  = cyc;
    done_cyc = cyc + 25;
    @(posedge clk); #1;
    meas_req = 1'b0;
    while (cyc < req_cyc + 18) begin
      @(posedge clk); #1;
    end
    check("midwait_busy", int'(busy), 1);
    #1;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    clear_req = 1'b1;
    samp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req_cyc = -1000;
    done_cyc = -1000;
    clear_req = 1'b0;
    chk_en = 1'b1;

    // normal measurement after reset
    run_meas(500, 500, 500, 500, -1, 1'b0);
    check_results("postrst", 500, 1, 0);
    check("postrst_latency", last_done_cyc - req_cyc, 25);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
